// File: rtl/mem_responder.sv
// Single-outstanding memory responder: word-addressed RAM window with byte-strobed
// writes, a fixed programmable access latency and a sticky bus error flag.
module mem_responder #(
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        request_enable,
   input  logic        req_mode,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        response_enable,
   output logic [31:0] resp_data,
   output logic        busy,
   output logic        bus_error
);

   // Handshake: request_enable is a one-cycle valid; the responder is ready
   // whenever busy is low. A valid seen while busy is dropped and flags
   // bus_error. response_enable is a one-cycle valid with no back-pressure.

   localparam logic        MEMREQ_READ  = 1'b0;
   localparam logic        MEMREQ_WRITE = 1'b1;
   localparam int unsigned WORDS        = 1 << DEPTH_LOG2;
   localparam logic [32:0] WINDOW_BYTES = 33'(WORDS) << 2;
   localparam logic [3:0]  LAT_M1       = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RESPOND = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [3:0]              counter;
   logic [3:0]              counter_nxt;
   logic                    accept;

   logic                    mode_q;
   logic [31:0]             addr_q;
   logic [31:0]             wdata_q;
   logic [3:0]              wstrb_q;

   logic [31:0]             offset;
   logic                    in_window;
   logic [DEPTH_LOG2-1:0]   word_idx;
   logic [31:0]             old_word;
   logic [31:0]             lane_mask;
   logic [31:0]             new_word;
   logic                    commit;
   logic                    dropped;

   logic [31:0]             ram [WORDS];

   always_comb begin
      state_nxt   = state;
      counter_nxt = counter;
      accept      = 1'b0;
      case (state)
         IDLE: begin
            if (request_enable) begin
               accept      = 1'b1;
               counter_nxt = LAT_M1;
               if (LATENCY == 1) state_nxt = RESPOND;
               else              state_nxt = WAIT;
            end
         end
         WAIT: begin
            counter_nxt = counter - 4'd1;
            if (counter <= 4'd1) state_nxt = RESPOND;
         end
         RESPOND: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy    = (state != IDLE);
   assign dropped = request_enable && (state != IDLE);

   // Unsigned subtraction makes addresses below BASE_ADDR wrap high and fail the window test.
   assign offset    = addr_q - BASE_ADDR;
   assign in_window = ({1'b0, offset} < WINDOW_BYTES);
   assign word_idx  = offset[DEPTH_LOG2+1:2];
   assign old_word  = ram[word_idx];
   assign lane_mask = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
   assign new_word  = (old_word & ~lane_mask) | (wdata_q & lane_mask);
   assign commit    = (state == RESPOND) && !rst && in_window && (mode_q == MEMREQ_WRITE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         counter         <= 4'd0;
         response_enable <= 1'b0;
         resp_data       <= 32'h0;
         bus_error       <= 1'b0;
      end else begin
         state           <= state_nxt;
         counter         <= counter_nxt;
         response_enable <= (state == RESPOND);
         if (state == RESPOND) resp_data <= in_window ? old_word : 32'h0;
         if (((state == RESPOND) && !in_window) || dropped) bus_error <= 1'b1;
      end
   end

   // Request capture needs no reset: the fields are only consumed after an accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         mode_q  <= req_mode;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         wstrb_q <= req_wstrb;
      end
   end

   always_ff @(posedge clk) begin
      if (commit) ram[word_idx] <= new_word;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances with different latency/base settings,
// directed cases plus randomized traffic checked against a behavioural memory model.
module tb_mem_responder;

   localparam int N = 4;

   int unsigned lat_tab  [N] = '{2, 2, 4, 1};
   logic [31:0] base_tab [N] = '{32'h0, 32'h8000_0000, 32'h0, 32'h0};

   logic        clk = 1'b0;
   logic        rst       [N];
   logic        req_en    [N];
   logic        req_mode  [N];
   logic [31:0] req_addr  [N];
   logic [31:0] req_wdata [N];
   logic [3:0]  req_wstrb [N];
   logic        resp_en   [N];
   logic [31:0] resp_data [N];
   logic        busy      [N];
   logic        bus_err   [N];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      mem_responder #(
         .DEPTH_LOG2 (12),
         .BASE_ADDR  ((g == 1) ? 32'h8000_0000 : 32'h0),
         .LATENCY    ((g == 2) ? 4 : ((g == 3) ? 1 : 2))
      ) u_dut (
         .clk             (clk),
         .rst             (rst[g]),
         .request_enable  (req_en[g]),
         .req_mode        (req_mode[g]),
         .req_addr        (req_addr[g]),
         .req_wdata       (req_wdata[g]),
         .req_wstrb       (req_wstrb[g]),
         .response_enable (resp_en[g]),
         .resp_data       (resp_data[g]),
         .busy            (busy[g]),
         .bus_error       (bus_err[g])
      );
   end

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mdl_mem [longint];
   bit          mdl_err [N];
   logic [31:0] exp_q [$];
   bit          known_q [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: a sparse word store per instance; window is 4096 words of 4 bytes.
   task automatic mdl_access(input int u, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] ws);
      logic [31:0] off;
      logic [31:0] old;
      logic [31:0] nw;
      longint      k;
      bit          known;
      off = a - base_tab[u];
      if (off >= 32'h0000_4000) begin
         mdl_err[u] = 1'b1;
         exp_q.push_back(32'h0);
         known_q.push_back(1'b1);
      end else begin
         k     = longint'(u) * 65536 + longint'(off >> 2);
         known = mdl_mem.exists(k);
         old   = known ? mdl_mem[k] : 32'h0;
         exp_q.push_back(old);
         known_q.push_back(known);
         if (wr) begin
            nw = old;
            for (int b = 0; b < 4; b++)
               if (ws[b]) nw[8*b +: 8] = wd[8*b +: 8];
            if (known || ws == 4'hF) mdl_mem[k] = nw;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      for (int i = 0; i < N; i++) begin
         rst[i]       = 1'b1;
         req_en[i]    = 1'b0;
         req_mode[i]  = 1'b0;
         req_addr[i]  = 32'h0;
         req_wdata[i] = 32'h0;
         req_wstrb[i] = 4'h0;
         mdl_err[i]   = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("u%0d_rst_resp_en", i), resp_en[i], 0);
         chk($sformatf("u%0d_rst_resp_data", i), resp_data[i], 0);
         chk($sformatf("u%0d_rst_busy", i), busy[i], 0);
         chk($sformatf("u%0d_rst_bus_error", i), bus_err[i], 0);
         rst[i] = 1'b0;
      end
   endtask

   task automatic drive_req(input int u, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] ws);
      req_en[u]    = 1'b1;
      req_mode[u]  = wr;
      req_addr[u]  = a;
      req_wdata[u] = wd;
      req_wstrb[u] = ws;
   endtask

   task automatic run_txn(input int u, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws);
      int          k;
      logic [31:0] exp;
      bit          known;
      mdl_access(u, wr, a, wd, ws);
      @(posedge clk); #1;
      drive_req(u, wr, a, wd, ws);
      @(posedge clk); #1;
      req_en[u] = 1'b0;
      chk($sformatf("u%0d_busy_after_accept", u), busy[u], 1);
      k = 0;
      while (resp_en[u] !== 1'b1 && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      exp   = exp_q.pop_front();
      known = known_q.pop_front();
      chk($sformatf("u%0d_resp_seen", u), resp_en[u], 1);
      chk($sformatf("u%0d_latency", u), k, lat_tab[u]);
      if (known) chk($sformatf("u%0d_resp_data@%h", u, a), resp_data[u], exp);
      chk($sformatf("u%0d_busy_at_resp", u), busy[u], 0);
      chk($sformatf("u%0d_bus_error", u), bus_err[u], mdl_err[u]);
      @(posedge clk); #1;
      chk($sformatf("u%0d_resp_one_cycle", u), resp_en[u], 0);
      if (known) chk($sformatf("u%0d_resp_hold", u), resp_data[u], exp);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          n_resp;
      logic [31:0] addr;

      do_reset();

      // Full write, then byte-strobed merge and a zero-strobe write.
      run_txn(0, 1'b1, 32'h10, 32'h0123_4567, 4'hF);
      run_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0);
      run_txn(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
      run_txn(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
      run_txn(0, 1'b0, 32'h20, 32'h0, 4'h0);
      chk("u0_strobe_merge_const", resp_data[0], 32'h11BB_33DD);
      run_txn(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0);
      run_txn(0, 1'b0, 32'h20, 32'h0, 4'h0);

      // Out-of-window accesses on a high-based instance.
      run_txn(1, 1'b1, 32'h8000_3FFC, 32'h5555_AAAA, 4'hF);
      run_txn(1, 1'b1, 32'h8000_0000, 32'h0F0F_0F0F, 4'hF);
      run_txn(1, 1'b0, 32'h8000_4000, 32'h0, 4'h0);
      run_txn(1, 1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF);
      run_txn(1, 1'b0, 32'h8000_3FFC, 32'h0, 4'h0);
      run_txn(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0);

      // Overlapping request dropped; a request right after the response is accepted.
      @(posedge clk); #1;
      drive_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
      @(posedge clk); #1;
      drive_req(0, 1'b1, 32'h10, 32'hBAD0_BAD0, 4'hF);
      @(posedge clk); #1;
      req_en[0]  = 1'b0;
      mdl_err[0] = 1'b1;
      chk("u0_ovl_busy", busy[0], 1);
      chk("u0_ovl_no_early_resp", resp_en[0], 0);
      chk("u0_ovl_bus_error", bus_err[0], 1);
      @(posedge clk); #1;
      chk("u0_ovl_resp", resp_en[0], 1);
      chk("u0_ovl_resp_data", resp_data[0], 32'hDEAD_BEEF);
      chk("u0_ovl_busy_low", busy[0], 0);
      drive_req(0, 1'b0, 32'h20, 32'h0, 4'h0);
      @(posedge clk); #1;
      req_en[0] = 1'b0;
      chk("u0_ovl_single_resp", resp_en[0], 0);
      chk("u0_third_accepted", busy[0], 1);
      @(posedge clk); #1;
      chk("u0_third_wait", resp_en[0], 0);
      @(posedge clk); #1;
      chk("u0_third_resp", resp_en[0], 1);
      chk("u0_third_data", resp_data[0], 32'h11BB_33DD);
      run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0);

      // Reset during a LATENCY=4 write aborts it.
      run_txn(2, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF);
      @(posedge clk); #1;
      drive_req(2, 1'b1, 32'h40, 32'h1234_5678, 4'hF);
      @(posedge clk); #1;
      req_en[2] = 1'b0;
      chk("u2_abort_busy", busy[2], 1);
      @(posedge clk); #1;
      rst[2] = 1'b1;
      @(posedge clk); #1;
      rst[2] = 1'b0;
      chk("u2_abort_busy_low", busy[2], 0);
      chk("u2_abort_resp_en", resp_en[2], 0);
      chk("u2_abort_resp_data", resp_data[2], 0);
      n_resp = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (resp_en[2]) n_resp++;
      end
      chk("u2_abort_no_resp", n_resp, 0);
      run_txn(2, 1'b0, 32'h40, 32'h0, 4'h0);

      // LATENCY=1 with low address bits set.
      run_txn(3, 1'b1, 32'h10, 32'h1357_9BDF, 4'hF);
      run_txn(3, 1'b0, 32'h13, 32'h0, 4'h0);

      // Randomized traffic over a small initialised region.
      for (int u = 0; u < N; u += 3) begin
         for (int w = 0; w < 16; w++)
            run_txn(u, 1'b1, 32'h100 + 32'(w * 4), $urandom, 4'hF);
         repeat (60) begin
            addr = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = 32'h4000 + 32'($urandom_range(0, 255));
            run_txn(u, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the single-outstanding request/response bus driven by the address-translation unit (request_enable / req_mode / req_addr / req_wdata / req_wstrb out; response_enable / resp_data back).
- Backs a word-addressed on-chip RAM window with byte-strobed writes and a programmable fixed access latency.
- Used as the physical-memory target in core-level simulation and as the BRAM slave on FPGA.

Parameters:
- DEPTH_LOG2, 12, RAM holds 2**DEPTH_LOG2 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to the window size.
- LATENCY, 2, cycles from the accepting edge to the response_enable edge; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- request_enable  in  1  one-cycle request strobe.
- req_mode  in  1  MEMREQ_READ or MEMREQ_WRITE (def.sv encoding).
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wdata  in  32  write data.
- req_wstrb  in  4  byte enables; bit n enables byte lane n, i.e. bits [8n+7:8n].
- response_enable  out  1  one-cycle completion strobe, issued for reads and writes.
- resp_data  out  32  read data, or the pre-write word for writes.
- busy  out  1  high from the accepting edge until the response edge, inclusive.
- bus_error  out  1  sticky; set on an out-of-window access or on a request dropped while busy.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: response_enable=0, resp_data=0, busy=0, bus_error=0, state=IDLE, counter=0. RAM contents are not cleared.
- A reset asserted mid-transaction aborts it. No response is issued, and a pending write that has not yet committed is discarded.
- States:
  - IDLE: on request_enable=1, latch mode, addr, wdata and wstrb. Set busy=1, load counter=LATENCY-1, go to WAIT. If LATENCY=1, go directly to RESPOND.
  - WAIT: decrement counter each cycle. When the counter reaches 0, go to RESPOND.
  - RESPOND: perform the RAM access (read, or read-then-merge for a write). Drive response_enable=1 and resp_data for exactly one cycle, set busy=0 and return to IDLE.
- Latency:
  - A request sampled at edge T produces response_enable=1 visible after edge T+LATENCY.
  - A new request may be accepted on the edge immediately after the response cycle.
  - A request arriving during the response cycle itself is dropped.
- Addressing:
  - The access is in-window when req_addr - BASE_ADDR < 4*2**DEPTH_LOG2, computed unsigned in 32 bits.
  - Word index = (req_addr - BASE_ADDR)[DEPTH_LOG2+1:2].
- Out-of-window access: read returns resp_data=0; write leaves the RAM unchanged. In both cases the response is still issued and bus_error is set.
- Writes:
  - New word = per-lane select: req_wdata byte where the wstrb bit is 1, old byte otherwise.
  - wstrb=0 gives a response with no modification.
  - resp_data carries the old word.
- Read-after-write: a write completes before its response strobe, so a read issued afterwards returns the merged data.
- Overlapping request: request_enable=1 while busy=1 is ignored. The in-flight transaction is unaffected and bus_error is set.
- response_enable is never high for two consecutive cycles. resp_data holds its value until the next response.
- bus_error clears only on reset.

Test Plan:
- LATENCY=2, BASE=0:
  - Write 32'hDEADBEEF with wstrb=4'hF to 0x10 -> response_enable exactly 2 edges later, resp_data = prior word.
  - Then read 0x10 -> resp_data=32'hDEADBEEF.
- Byte strobe: word 0x20 = 32'h11223344; write 32'hAABBCCDD with wstrb=4'b0101 -> a subsequent read returns 32'h11BB33DD.
- Out of window: BASE=32'h8000_0000, DEPTH_LOG2=12.
  - Read 32'h8000_4000 -> resp_data=0, response issued, bus_error=1.
  - Write 32'h7FFF_FFFC -> RAM unchanged, bus_error remains 1.
- Back-to-back and overlap: issue a read, then pulse request_enable again while busy -> only one response, bus_error=1. A third request issued the cycle after the response is accepted and answered normally.
- Reset mid-flight: LATENCY=4; accept a write to 0x40, then assert rst for 1 cycle after 2 edges -> no response_enable, busy=0, and word 0x40 is unchanged on a subsequent read.
- LATENCY=1 and misalignment: read 0x13 -> same data as 0x10, response on the very next edge.
